// File: rtl/swan128_theta_round_stage.sv
// swan128_theta_round_stage
//
// Round-combine stage that sits directly after the 64-bit half-block S-box
// layer of the SWAN128 datapath. It applies the rotate-XOR diffusion
//   theta(x) = x ^ rotl(x,ROT_A) ^ rotl(x,ROT_B)
// to the S-box output, XORs in the left half and the round key, and performs
// the Feistel swap:
//   out_l = in_r
//   out_r = in_l ^ theta(in_beta) ^ in_rk
// The result is computed combinationally and stored in a 2-entry FIFO. Each
// entry is tagged with the round index taken from an internal round counter.
//
// Bit ordering: vectors are [0:SIDE_SIZE-1] with bit 0 as the MSB, so
// rotl(x,n)[i] = x[(i+n) mod SIDE_SIZE] is an ordinary left rotate.
//
// Optional feature: macro SWAN_ROUND_PARITY_EN adds out_par[0:1]
// (out_par[0] = XOR-reduce of out_l, out_par[1] = XOR-reduce of out_r),
// computed at push time and stored with the entry.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   flush             synchronous clear of FIFO and round counter
//   in_valid/in_ready input handshake; in_ready is a register
//   in_first          beat is round 0 of a new block
//   in_beta, in_l, in_r, in_rk   S-box output, left half, right half, round key
//   out_valid/out_ready          output handshake
//   out_l, out_r      new halves of the head entry
//   out_round         round index of the head entry
//   out_last          head entry is round ROUNDS-1
//   out_par           (SWAN_ROUND_PARITY_EN only) stored parity of head entry
//
// Handshake: a beat moves on a side when valid && ready are both high at a
// rising clock edge. Valid never depends on ready. in_ready is registered
// (count_d != 2), so out_ready has no combinational path to in_ready.
// Flush has priority over both push and pop; a push in a flush cycle is lost.

module swan128_theta_round_stage #(
  parameter int SIDE_SIZE = 64,
  parameter int ROT_A     = 8,
  parameter int ROT_B     = 25,
  parameter int ROUNDS    = 64,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic [0:SIDE_SIZE-1] in_beta,
  input  logic [0:SIDE_SIZE-1] in_l,
  input  logic [0:SIDE_SIZE-1] in_r,
  input  logic [0:SIDE_SIZE-1] in_rk,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] out_l,
  output logic [0:SIDE_SIZE-1] out_r,
  output logic [CNT_W-1:0]     out_round,
`ifdef SWAN_ROUND_PARITY_EN
  output logic [0:1]           out_par,
`endif
  output logic                 out_last
);

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  typedef struct packed {
    logic [0:SIDE_SIZE-1] l;
    logic [0:SIDE_SIZE-1] r;
    logic [CNT_W-1:0]     rnd;
`ifdef SWAN_ROUND_PARITY_EN
    logic [0:1]           par;
`endif
  } entry_t;

  // Left shift moves bits toward index 0 (the MSB), giving y[i] = x[i+n].
  function automatic logic [0:SIDE_SIZE-1] rotl(input logic [0:SIDE_SIZE-1] x,
                                                input int unsigned n);
    rotl = (x << n) | (x >> (SIDE_SIZE - n));
  endfunction

  function automatic logic [0:SIDE_SIZE-1] theta(input logic [0:SIDE_SIZE-1] x);
    theta = x ^ rotl(x, ROT_A) ^ rotl(x, ROT_B);
  endfunction

  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             in_ready_q, in_ready_d;

  logic             push, pop;
  entry_t           new_e;

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  assign out_l     = head_q.l;
  assign out_r     = head_q.r;
  assign out_round = head_q.rnd;
  assign out_last  = (head_q.rnd == LAST_RND);
`ifdef SWAN_ROUND_PARITY_EN
  assign out_par   = head_q.par;
`endif

  // Incoming entry: combined halves plus round tag (and parity if enabled).
  always_comb begin
    new_e     = '0;
    new_e.l   = in_r;
    new_e.r   = in_l ^ theta(in_beta) ^ in_rk;
    new_e.rnd = in_first ? '0 : rcnt_q;
`ifdef SWAN_ROUND_PARITY_EN
    new_e.par = {^new_e.l, ^new_e.r};
`endif
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rcnt_d  = rcnt_q;

    if (flush) begin
      // Same visible result as reset; the stale tail is never exposed.
      head_d  = '0;
      count_d = 2'd0;
      rcnt_d  = '0;
    end else begin
      if (push) begin
        if (in_first)                rcnt_d = CNT_W'(1);
        else if (rcnt_q == LAST_RND) rcnt_d = '0;
        else                         rcnt_d = rcnt_q + CNT_W'(1);
      end

      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = new_e;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            // Head leaves and the new beat takes its place: no bubble.
            head_d = new_e;
          end else if (push) begin
            tail_d  = new_e;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          // in_ready is low here, so push cannot occur.
          if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end

    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      rcnt_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rcnt_q     <= rcnt_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_swan128_theta_round_stage.sv
module tb_swan128_theta_round_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_first;
  logic [0:63] in_beta, in_l, in_r, in_rk;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] out_l, out_r;
  logic [7:0]  out_round;
  logic        out_last;
`ifdef SWAN_ROUND_PARITY_EN
  logic [0:1]  out_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  swan128_theta_round_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_beta   (in_beta),
    .in_l      (in_l),
    .in_r      (in_r),
    .in_rk     (in_rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_round (out_round),
`ifdef SWAN_ROUND_PARITY_EN
    .out_par   (out_par),
`endif
    .out_last  (out_last)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic first, input logic [63:0] beta,
                       input logic [63:0] l, input logic [63:0] r, input logic [63:0] rk);
    in_valid = v;
    in_first = first;
    in_beta  = beta;
    in_l     = l;
    in_r     = r;
    in_rk    = rk;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    step();
    step();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_l",     out_l,          64'd0);
    check("rst_out_r",     out_r,          64'd0);
    check("rst_out_round", 64'(out_round), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
`ifdef SWAN_ROUND_PARITY_EN
    check("rst_out_par",   64'(out_par),   64'd0);
`endif
    rst = 1'b0;
    step();

    // Theta on a single MSB bit
    drive(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h0, 64'h1234_5678_9ABC_DEF0, 64'h0);
    step();
    check("th1_valid", 64'(out_valid), 64'd1);
    check("th1_out_l", out_l, 64'h1234_5678_9ABC_DEF0);
    check("th1_out_r", out_r, 64'h8000_0000_0100_0080);
    check("th1_round", 64'(out_round), 64'd0);
    check("th1_last",  64'(out_last), 64'd0);
`ifdef SWAN_ROUND_PARITY_EN
    check("th1_par",   64'(out_par), 64'd1);
`endif

    // LSB bit with left half and round key (round 1), pushed while head pops
    drive(1'b1, 1'b0, 64'h0000_0000_0000_0001, 64'hFFFF_0000_FFFF_0000,
          64'hAAAA_AAAA_5555_5555, 64'h0F0F_0F0F_0F0F_0F0F);
    step();
    check("th2_valid", 64'(out_valid), 64'd1);
    check("th2_out_l", out_l, 64'hAAAA_AAAA_5555_5555);
    check("th2_out_r", out_r, 64'hF0F0_0F0F_F2F0_0E0E);
    check("th2_round", 64'(out_round), 64'd1);

    // Mid-word bit, round 2; simultaneous push/pop at count 1 again
    drive(1'b1, 1'b0, 64'h0000_0001_0000_0000, 64'h0, 64'h0000_0000_0000_0003, 64'h0);
    step();
    check("th3_valid",    64'(out_valid), 64'd1);
    check("th3_in_ready", 64'(in_ready),  64'd1);
    check("th3_out_r",    out_r, 64'h0200_0101_0000_0000);
    check("th3_out_l",    out_l, 64'h3);
    check("th3_round",    64'(out_round), 64'd2);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    step();
    check("th3_drain", 64'(out_valid), 64'd0);

    // Backpressure: A, B, C back-to-back with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 64'h0, 64'hA, 64'h0, 64'h0);
    step();
    check("bp_a_valid", 64'(out_valid), 64'd1);
    check("bp_a_ready", 64'(in_ready),  64'd1);
    check("bp_a_head",  out_r, 64'hA);
    drive(1'b1, 1'b0, 64'h0, 64'hB, 64'h0, 64'h0);
    step();
    check("bp_b_ready", 64'(in_ready), 64'd0);
    check("bp_b_head",  out_r, 64'hA);
    drive(1'b1, 1'b0, 64'h0, 64'hC, 64'h0, 64'h0);
    step();
    check("bp_c_ready", 64'(in_ready), 64'd0);
    check("bp_c_hold",  out_r, 64'hA);
    check("bp_c_round", 64'(out_round), 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_pop_b",   out_r, 64'hB);
    check("bp_pop_b_r", 64'(out_round), 64'd1);
    check("bp_ready_1", 64'(in_ready), 64'd1);
    step();
    check("bp_pop_c",   out_r, 64'hC);
    check("bp_pop_c_r", 64'(out_round), 64'd2);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush with two entries stored and a push in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 64'h0, 64'hD, 64'h0, 64'h0);
    step();
    drive(1'b1, 1'b0, 64'h0, 64'hE, 64'h0, 64'h0);
    step();
    check("fl_full", 64'(in_ready), 64'd0);
    drive(1'b1, 1'b0, 64'h0, 64'hF, 64'h0, 64'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    check("fl_out_r", out_r, 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 64'h0, 64'h6, 64'h0, 64'h0);
    step();
    check("fl_next_valid", 64'(out_valid), 64'd1);
    check("fl_next_r",     out_r, 64'h6);
    check("fl_next_round", 64'(out_round), 64'd0);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    step();

    // Round wrap: 64 rounds then one more without in_first
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, (i == 0), 64'h0, 64'h0, 64'(i), 64'h0);
      step();
      check("wrap_l",     out_l, 64'(i));
      check("wrap_round", 64'(out_round), 64'(i));
      check("wrap_last",  64'(out_last), (i == 63) ? 64'd1 : 64'd0);
    end
    drive(1'b1, 1'b0, 64'h0, 64'h0, 64'h41, 64'h0);
    step();
    check("wrap65_round", 64'(out_round), 64'd0);
    check("wrap65_last",  64'(out_last),  64'd0);
    check("wrap65_l",     out_l, 64'h41);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 64'h0, 64'h77, 64'h99, 64'h0);
    step();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_ready", 64'(in_ready),  64'd1);
    check("ar_out_l", out_l, 64'd0);
    check("ar_out_r", out_r, 64'd0);
    check("ar_round", 64'(out_round), 64'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 64'h0, 64'h5, 64'h0, 64'h0);
    step();
    check("ar_next_round", 64'(out_round), 64'd0);
    check("ar_next_r",     out_r, 64'h5);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    step();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
